cpu_flag_stack: RTL and testbench

CPU_FLAG_STACK -- requirements
Module: cpu_flag_stack

---
 rtl/cpu_flag_stack.sv | 122 ++++++++++++
 tb/tb_cpu_flag_stack.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_flag_stack.sv
// cpu_flag_stack
//   LIFO save/restore stack for the CPU {Carry, Zero, Borrow} flags.
//   PUSH saves the live flags. POP presents the top entry on RC/RZ/RB with a
//   one-cycle RVALID strobe. PUSH+POP swaps the top entry, or bypasses the
//   live flags straight to the outputs when the stack is empty.
//
// Parameters
//   DEPTH  number of stored entries (2..16)
//   CNT_W  COUNT width, 2**CNT_W > DEPTH
//
// Ports
//   CLK, RST        clock (rising edge), asynchronous active-high reset
//   CLR             synchronous clear of COUNT/RVALID/error flags
//   PUSH, POP       stack operations
//   C, Z, B         live flags from the CPU flag register
//   RC, RZ, RB      restored flags (registered, hold when RVALID=0)
//   RVALID          one-cycle restore strobe
//   FULL, EMPTY     combinational status from COUNT
//   COUNT           number of valid entries
//   OVF, UNF        sticky overflow/underflow errors, only present when
//                   CPU_FLAG_STACK_ERR_EN is defined
module cpu_flag_stack #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             PUSH,
  input  logic             POP,
  input  logic             C,
  input  logic             Z,
  input  logic             B,
  output logic             RC,
  output logic             RZ,
  output logic             RB,
  output logic             RVALID,
  output logic             FULL,
  output logic             EMPTY,
  output logic [CNT_W-1:0] COUNT
`ifdef CPU_FLAG_STACK_ERR_EN
  ,
  output logic             OVF,
  output logic             UNF
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] top_idx;
  logic [AW-1:0] wr_idx;
  logic          do_push;
  logic          do_pop;
  logic          do_swap;
  logic          do_byp;
  logic          wr_en;

  assign FULL  = (COUNT == CNT_W'(DEPTH));
  assign EMPTY = (COUNT == '0);

  // Operation decode; CLR overrides everything, including storage writes.
  always_comb begin
    do_push = PUSH & ~POP & ~FULL  & ~CLR;
    do_pop  = POP  & ~PUSH & ~EMPTY & ~CLR;
    do_swap = PUSH & POP  & ~EMPTY & ~CLR;
    do_byp  = PUSH & POP  &  EMPTY & ~CLR;
    top_idx = AW'(COUNT - 1'b1);
    wr_idx  = do_swap ? top_idx : AW'(COUNT);
    wr_en   = (do_push | do_swap) & ~RST;
  end

  // Storage is deliberately not reset; only entries below COUNT are readable.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      mem[wr_idx] <= {C, Z, B};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      COUNT        <= '0;
      RVALID       <= 1'b0;
      {RC, RZ, RB} <= '0;
    end else if (CLR) begin
      COUNT  <= '0;
      RVALID <= 1'b0;
    end else begin
      RVALID <= do_pop | do_swap | do_byp;
      if (do_pop || do_swap) begin
        {RC, RZ, RB} <= mem[top_idx];
      end else if (do_byp) begin
        {RC, RZ, RB} <= {C, Z, B};
      end
      if (do_push) begin
        COUNT <= COUNT + 1'b1;
      end else if (do_pop) begin
        COUNT <= COUNT - 1'b1;
      end
    end
  end

`ifdef CPU_FLAG_STACK_ERR_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      OVF <= 1'b0;
      UNF <= 1'b0;
    end else if (CLR) begin
      OVF <= 1'b0;
      UNF <= 1'b0;
    end else begin
      if (PUSH && !POP && FULL) begin
        OVF <= 1'b1;
      end
      if (POP && !PUSH && EMPTY) begin
        UNF <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cpu_flag_stack.sv
module tb_cpu_flag_stack;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             CLR = 1'b0;
  logic             PUSH = 1'b0;
  logic             POP = 1'b0;
  logic             C = 1'b0;
  logic             Z = 1'b0;
  logic             B = 1'b0;
  logic             RC, RZ, RB, RVALID, FULL, EMPTY;
  logic [CNT_W-1:0] COUNT;
  logic             ovf_s, unf_s;

  int checks   = 0;
  int failures = 0;

  // Reference model: a queue whose back is the top of stack.
  bit [2:0] stk[$];
  bit [2:0] mr;
  bit       mrv, movf, munf;

  cpu_flag_stack #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .PUSH(PUSH), .POP(POP),
    .C(C), .Z(Z), .B(B),
    .RC(RC), .RZ(RZ), .RB(RB), .RVALID(RVALID),
    .FULL(FULL), .EMPTY(EMPTY), .COUNT(COUNT)
`ifdef CPU_FLAG_STACK_ERR_EN
    , .OVF(ovf_s), .UNF(unf_s)
`endif
  );

`ifndef CPU_FLAG_STACK_ERR_EN
  assign ovf_s = 1'b0;
  assign unf_s = 1'b0;
`endif

  always #5 CLK = ~CLK;

  // Packed view: {RVALID, RC, RZ, RB, FULL, EMPTY, COUNT[3:0], OVF, UNF}
  function automatic logic [11:0] dut_vec();
    return {RVALID, RC, RZ, RB, FULL, EMPTY, COUNT, ovf_s, unf_s};
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [1:0] err;
`ifdef CPU_FLAG_STACK_ERR_EN
    err = {movf, munf};
`else
    err = 2'b00;
`endif
    return {mrv, mr, stk.size() == DEPTH, stk.size() == 0, 4'(stk.size()), err};
  endfunction

  task automatic model_reset();
    stk.delete();
    mr   = '0;
    mrv  = 1'b0;
    movf = 1'b0;
    munf = 1'b0;
  endtask

  task automatic model_edge(input bit push, input bit pop, input bit clr, input bit [2:0] f);
    if (clr) begin
      stk.delete();
      mrv  = 1'b0;
      movf = 1'b0;
      munf = 1'b0;
    end else if (push && pop) begin
      mrv = 1'b1;
      if (stk.size() == 0) begin
        mr = f;
      end else begin
        mr = stk[stk.size()-1];
        stk[stk.size()-1] = f;
      end
    end else if (push) begin
      mrv = 1'b0;
      if (stk.size() == DEPTH) movf = 1'b1;
      else stk.push_back(f);
    end else if (pop) begin
      if (stk.size() == 0) begin
        mrv  = 1'b0;
        munf = 1'b1;
      end else begin
        mr  = stk.pop_back();
        mrv = 1'b1;
      end
    end else begin
      mrv = 1'b0;
    end
  endtask

  // Drive inputs, take one rising edge, update the model, sample 1 ns later.
  task automatic step(input bit push, input bit pop, input bit clr, input bit [2:0] f);
    PUSH = push;
    POP  = pop;
    CLR  = clr;
    {C, Z, B} = f;
    @(posedge CLK);
    model_edge(push, pop, clr, f);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b", dut_vec(), exp_vec());
    end
    @(negedge CLK);
    RST = 1'b0;
    step(0, 0, 0, 3'b000);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_idle: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_lifo();
    bit [2:0] pushes[3] = '{3'b101, 3'b010, 3'b111};
    bit [2:0] lit[3]    = '{3'b111, 3'b010, 3'b101};
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, pushes[i]);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL lifo_push%0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 3'b000);
      checks++;
      if ({RVALID, RC, RZ, RB, COUNT} !== {1'b1, lit[i], 4'(2 - i)}) begin
        failures++;
        $display("FAIL lifo_pop%0d: got %b expected %b", i,
                 {RVALID, RC, RZ, RB, COUNT}, {1'b1, lit[i], 4'(2 - i)});
      end
    end
    step(0, 0, 0, 3'b000);
    checks++;
    if ({RVALID, EMPTY, RC, RZ, RB} !== 5'b01101) begin
      failures++;
      $display("FAIL lifo_after: got %b expected %b", {RVALID, EMPTY, RC, RZ, RB}, 5'b01101);
    end
  endtask

  task automatic test_overflow();
    bit [2:0] v, eighth;
    eighth = '0;
    for (int i = 0; i < 9; i++) begin
      v = 3'($urandom);
      if (i == 7) eighth = v;
      step(1, 0, 0, v);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL ovf_push%0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if ({FULL, COUNT} !== {1'b1, 4'd8}) begin
      failures++;
      $display("FAIL ovf_full: got %b expected %b", {FULL, COUNT}, {1'b1, 4'd8});
    end
`ifdef CPU_FLAG_STACK_ERR_EN
    checks++;
    if (ovf_s !== 1'b1) begin
      failures++;
      $display("FAIL ovf_flag: got %b expected 1", ovf_s);
    end
`endif
    step(0, 1, 0, 3'b000);
    checks++;
    if ({RVALID, RC, RZ, RB} !== {1'b1, eighth}) begin
      failures++;
      $display("FAIL ovf_pop: got %b expected %b", {RVALID, RC, RZ, RB}, {1'b1, eighth});
    end
    step(0, 0, 1, 3'b000);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL ovf_clr: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_underflow();
    step(0, 1, 0, 3'b000);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL unf_pop: got %b expected %b", dut_vec(), exp_vec());
    end
    step(0, 0, 1, 3'b000);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL unf_clr: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_swap_bypass();
    step(1, 0, 0, 3'b100);
    step(1, 1, 0, 3'b011);
    checks++;
    if ({RVALID, RC, RZ, RB, COUNT} !== {1'b1, 3'b100, 4'd1}) begin
      failures++;
      $display("FAIL swap: got %b expected %b", {RVALID, RC, RZ, RB, COUNT}, {1'b1, 3'b100, 4'd1});
    end
    step(0, 1, 0, 3'b000);
    checks++;
    if ({RVALID, RC, RZ, RB, COUNT} !== {1'b1, 3'b011, 4'd0}) begin
      failures++;
      $display("FAIL swap_pop: got %b expected %b", {RVALID, RC, RZ, RB, COUNT}, {1'b1, 3'b011, 4'd0});
    end
    step(1, 1, 0, 3'b110);
    checks++;
    if ({RVALID, RC, RZ, RB, COUNT} !== {1'b1, 3'b110, 4'd0}) begin
      failures++;
      $display("FAIL bypass: got %b expected %b", {RVALID, RC, RZ, RB, COUNT}, {1'b1, 3'b110, 4'd0});
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL bypass_model: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_reset_midcycle();
    step(1, 0, 0, 3'b111);
    step(1, 0, 0, 3'b101);
    PUSH = 1'b0;
    POP  = 1'b1;
    #3;
    RST = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL rst_async: got %b expected %b", dut_vec(), exp_vec());
    end
    @(posedge CLK);
    #1;
    POP = 1'b0;
    @(negedge CLK);
    RST = 1'b0;
    step(0, 0, 0, 3'b000);
    checks++;
    if ({RVALID, COUNT, RC, RZ, RB} !== '0) begin
      failures++;
      $display("FAIL rst_release: got %b expected %b", {RVALID, COUNT, RC, RZ, RB}, 8'b0);
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 3'(i + 1));
    step(1, 0, 1, 3'b111);
    checks++;
    if ({RVALID, COUNT, EMPTY} !== {1'b0, 4'd0, 1'b1}) begin
      failures++;
      $display("FAIL clr_push: got %b expected %b", {RVALID, COUNT, EMPTY}, {1'b0, 4'd0, 1'b1});
    end
    step(0, 1, 0, 3'b000);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL clr_then_pop: got %b expected %b", dut_vec(), exp_vec());
    end
    step(0, 0, 1, 3'b000);
  endtask

  task automatic test_random();
    bit push, pop, clr;
    for (int i = 0; i < 400; i++) begin
      clr  = ($urandom_range(0, 31) == 0);
      push = ($urandom_range(0, 99) < ((i % 100) < 50 ? 70 : 30));
      pop  = ($urandom_range(0, 99) < ((i % 100) < 50 ? 30 : 70));
      step(push, pop, clr, 3'($urandom));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_%0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lifo();
    test_overflow();
    test_underflow();
    test_swap_bypass();
    test_reset_midcycle();
    test_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
